// File: rtl/placar_batalha.sv
// Match scoreboard behind the battle comparator: counts plays and runs a best-of-N match.
// Latency: every play, start and verdict is visible right after the sampling edge.
// Backpressure: none; one play accepted per cycle while a match runs, ignored otherwise.
module placar_batalha #(
    parameter int RODADAS         = 5,
    parameter int ACERTOS_VITORIA = 3,
    parameter int MAX_INVALIDAS   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iniciar,
    input  logic       jogar,
    input  logic       s1,
    input  logic       s2,
    output logic [3:0] acertos,
    output logic [3:0] rodada,
    output logic [3:0] invalidas,
    output logic       ocupado,
    output logic       fim,
    output logic [1:0] resultado,
    output logic [1:0] ultimo
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        JOGANDO = 2'd1,
        FIM     = 2'd2
    } estado_t;

    localparam logic [3:0] ALVO_ACERTOS = 4'(ACERTOS_VITORIA);
    localparam logic [3:0] LIM_INVALIDAS = 4'(MAX_INVALIDAS);
    // Misses at which B can no longer reach the hit target even winning every remaining round.
    localparam logic [3:0] LIM_ERROS = 4'(RODADAS - ACERTOS_VITORIA + 1);

    localparam logic [1:0] RES_NENHUM  = 2'b00;
    localparam logic [1:0] RES_A       = 2'b01;
    localparam logic [1:0] RES_B       = 2'b10;
    localparam logic [1:0] RES_ANULADA = 2'b11;

    localparam logic [1:0] ULT_NENHUM   = 2'b00;
    localparam logic [1:0] ULT_ERRO     = 2'b01;
    localparam logic [1:0] ULT_ACERTO   = 2'b10;
    localparam logic [1:0] ULT_INVALIDA = 2'b11;

    estado_t    estado;
    estado_t    estado_nx;

    logic       jogada;
    logic       partida_nova;
    logic [3:0] acertos_p;
    logic [3:0] rodada_p;
    logic [3:0] invalidas_p;
    logic [3:0] erros_p;
    logic [1:0] ultimo_p;
    logic [1:0] veredito;
    logic       encerra;

    logic [3:0] acertos_nx;
    logic [3:0] rodada_nx;
    logic [3:0] invalidas_nx;
    logic [1:0] resultado_nx;
    logic [1:0] ultimo_nx;
    logic       ocupado_nx;
    logic       fim_nx;

    assign jogada       = (estado == JOGANDO) && jogar;
    assign partida_nova = (estado != JOGANDO) && iniciar;

    // Post-play counter values; the end checks must see the play being counted now.
    always_comb begin
        acertos_p   = acertos;
        rodada_p    = rodada;
        invalidas_p = invalidas;
        ultimo_p    = ultimo;
        if (jogada) begin
            if (!s2) begin
                invalidas_p = invalidas + 4'd1;
                ultimo_p    = ULT_INVALIDA;
            end else begin
                rodada_p = rodada + 4'd1;
                if (s1) begin
                    acertos_p = acertos + 4'd1;
                    ultimo_p  = ULT_ACERTO;
                end else begin
                    ultimo_p = ULT_ERRO;
                end
            end
        end
    end

    assign erros_p = rodada_p - acertos_p;

    always_comb begin
        veredito = RES_NENHUM;
        if (invalidas_p == LIM_INVALIDAS) begin
            veredito = RES_ANULADA;
        end else if (acertos_p == ALVO_ACERTOS) begin
            veredito = RES_B;
        end else if (erros_p == LIM_ERROS) begin
            veredito = RES_A;
        end
    end

    assign encerra = jogada && (veredito != RES_NENHUM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado <= OCIOSO;
        end else begin
            estado <= estado_nx;
        end
    end

    always_comb begin
        estado_nx = estado;
        case (estado)
            OCIOSO:  if (iniciar) estado_nx = JOGANDO;
            JOGANDO: if (encerra) estado_nx = FIM;
            FIM:     if (iniciar) estado_nx = JOGANDO;
            default: estado_nx = OCIOSO;
        endcase
    end

    always_comb begin
        acertos_nx   = acertos;
        rodada_nx    = rodada;
        invalidas_nx = invalidas;
        resultado_nx = resultado;
        ultimo_nx    = ultimo;
        if (partida_nova) begin
            acertos_nx   = 4'd0;
            rodada_nx    = 4'd0;
            invalidas_nx = 4'd0;
            resultado_nx = RES_NENHUM;
            ultimo_nx    = ULT_NENHUM;
        end else if (jogada) begin
            acertos_nx   = acertos_p;
            rodada_nx    = rodada_p;
            invalidas_nx = invalidas_p;
            ultimo_nx    = ultimo_p;
            if (encerra) resultado_nx = veredito;
        end
        ocupado_nx = (estado_nx == JOGANDO);
        fim_nx     = (estado_nx == FIM);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acertos   <= 4'd0;
            rodada    <= 4'd0;
            invalidas <= 4'd0;
            resultado <= RES_NENHUM;
            ultimo    <= ULT_NENHUM;
            ocupado   <= 1'b0;
            fim       <= 1'b0;
        end else begin
            acertos   <= acertos_nx;
            rodada    <= rodada_nx;
            invalidas <= invalidas_nx;
            resultado <= resultado_nx;
            ultimo    <= ultimo_nx;
            ocupado   <= ocupado_nx;
            fim       <= fim_nx;
        end
    end

endmodule

// File: tb/tb_placar_batalha.sv
// Bench for placar_batalha: directed match scenarios plus random play streams against a scoreboard model.
module tb_placar_batalha;

    localparam int RODADAS = 5;
    localparam int ALVO    = 3;
    localparam int MAX_INV = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       iniciar = 1'b0;
    logic       jogar = 1'b0;
    logic       s1 = 1'b0;
    logic       s2 = 1'b0;
    logic [3:0] acertos, rodada, invalidas;
    logic       ocupado, fim;
    logic [1:0] resultado, ultimo;

    placar_batalha #(
        .RODADAS(RODADAS),
        .ACERTOS_VITORIA(ALVO),
        .MAX_INVALIDAS(MAX_INV)
    ) dut (
        .clk(clk), .rst(rst), .iniciar(iniciar), .jogar(jogar), .s1(s1), .s2(s2),
        .acertos(acertos), .rodada(rodada), .invalidas(invalidas),
        .ocupado(ocupado), .fim(fim), .resultado(resultado), .ultimo(ultimo)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] ac;
        logic [3:0] rod;
        logic [3:0] inv;
        logic       ocu;
        logic       fim;
        logic [1:0] res;
        logic [1:0] ult;
    } obs_t;

    obs_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: match phase plus plain tallies of the plays.
    int         m_fase;   // 0 idle, 1 playing, 2 over
    int         m_hits, m_rounds, m_inv;
    logic [1:0] m_res, m_ult;

    task automatic m_reset();
        m_fase = 0; m_hits = 0; m_rounds = 0; m_inv = 0; m_res = 2'b00; m_ult = 2'b00;
    endtask

    task automatic m_apply(input logic ini, input logic jog, input logic a, input logic b);
        if (m_fase != 1) begin
            if (ini) begin
                m_hits = 0; m_rounds = 0; m_inv = 0; m_res = 2'b00; m_ult = 2'b00;
                m_fase = 1;
            end
        end else if (jog) begin
            if (!b) begin
                m_inv++;
                m_ult = 2'b11;
            end else begin
                m_rounds++;
                if (a) begin m_hits++; m_ult = 2'b10; end
                else   m_ult = 2'b01;
            end
            if (m_inv == MAX_INV) begin
                m_res = 2'b11; m_fase = 2;
            end else if (m_hits == ALVO) begin
                m_res = 2'b10; m_fase = 2;
            end else if (m_hits + (RODADAS - m_rounds) < ALVO) begin
                m_res = 2'b01; m_fase = 2;
            end
        end
    endtask

    function automatic obs_t m_obs();
        obs_t o;
        o.ac  = 4'(m_hits);
        o.rod = 4'(m_rounds);
        o.inv = 4'(m_inv);
        o.ocu = (m_fase == 1);
        o.fim = (m_fase == 2);
        o.res = m_res;
        o.ult = m_ult;
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.ac = acertos; o.rod = rodada; o.inv = invalidas;
        o.ocu = ocupado; o.fim = fim; o.res = resultado; o.ult = ultimo;
        return o;
    endfunction

    task automatic cmp(input string name, input string tag, input logic [3:0] act, input logic [3:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s at %0t: got %0d, expected %0d", tag, name, $time, act, req);
        end
    endtask

    task automatic check_obs(input obs_t got, input obs_t req, input string tag);
        cmp("acertos",   tag, got.ac,  req.ac);
        cmp("rodada",    tag, got.rod, req.rod);
        cmp("invalidas", tag, got.inv, req.inv);
        cmp("ocupado",   tag, {3'b0, got.ocu}, {3'b0, req.ocu});
        cmp("fim",       tag, {3'b0, got.fim}, {3'b0, req.fim});
        cmp("resultado", tag, {2'b0, got.res}, {2'b0, req.res});
        cmp("ultimo",    tag, {2'b0, got.ult}, {2'b0, req.ult});
    endtask

    // Monitor: the registered outputs settle right after each edge; compare against the queued expectation.
    always @(posedge clk) begin
        obs_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_obs(dut_obs(), e, "ciclo");
        end
    end

    task automatic step(input logic ini, input logic jog, input logic a, input logic b);
        @(negedge clk);
        iniciar = ini; jogar = jog; s1 = a; s2 = b;
        m_apply(ini, jog, a, b);
        exp_q.push_back(m_obs());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom_range(0, 1), $urandom_range(0, 1));
    endtask

    // Reset asserted between edges must clear the outputs before the next edge arrives.
    task automatic async_reset();
        @(negedge clk);
        iniciar = 1'b0; jogar = 1'b0;
        #2 rst = 1'b1;
        #1;
        m_reset();
        check_obs(dut_obs(), m_obs(), "rst_assinc");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        m_reset();
        #12;
        check_obs(dut_obs(), m_obs(), "reset");
        @(negedge clk);
        rst = 1'b0;

        // Three straight hits: B wins on the third strobe.
        step(1, 0, 0, 0);
        step(0, 1, 1, 1); step(0, 1, 1, 1); step(0, 1, 1, 1);
        idle(2);

        // Hit then three misses: A wins early.
        step(1, 0, 0, 0);
        step(0, 1, 1, 1); step(0, 1, 0, 1); step(0, 1, 0, 1); step(0, 1, 0, 1);
        idle(1);

        // Three invalid plays, one carrying a hit flag: match voided.
        step(1, 0, 0, 0);
        step(0, 1, 0, 0); step(0, 1, 1, 0); step(0, 1, 0, 0);
        idle(1);

        // Plays ignored in FIM and OCIOSO; start and play together from FIM starts a clean match.
        step(0, 1, 1, 1);
        step(1, 1, 1, 1);
        idle(1);
        async_reset();
        step(0, 1, 1, 1);
        step(0, 1, 0, 0);

        // Mid-match reset after two hits.
        step(1, 0, 0, 0);
        step(0, 1, 1, 1); step(0, 1, 1, 1);
        async_reset();
        idle(1);

        // Back-to-back: miss, hit, invalid, hit, hit.
        step(1, 0, 0, 0);
        step(0, 1, 0, 1); step(0, 1, 1, 1); step(0, 1, 1, 0); step(0, 1, 1, 1); step(0, 1, 1, 1);
        idle(1);

        // Start ignored while playing.
        step(1, 0, 0, 0);
        step(0, 1, 0, 1); step(1, 1, 1, 1); step(1, 0, 0, 0); step(0, 1, 0, 1);
        idle(1);

        // Random play streams.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_reset();
            end else begin
                step(($urandom_range(0, 7) == 0),
                     ($urandom_range(0, 1) == 1),
                     ($urandom_range(0, 1) == 1),
                     ($urandom_range(0, 4) != 0));
            end
        end

        @(negedge clk);
        iniciar = 1'b0; jogar = 1'b0;
        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/placar_batalha.md
# placar_batalha

Match scoreboard placed directly downstream of the battle comparator. Each play strobe samples the comparator's hit flag (`s1`) and validity flag (`s2`). The block counts valid rounds, hits, misses and invalid plays, and runs a best-of-N match to completion. It reports player B winning by reaching the hit target, player A winning once B can no longer reach it, or the match being voided by too many invalid plays.

## Interface
- `RODADAS`, 5: rounds per match; legal range 1..15.
- `ACERTOS_VITORIA`, 3: hits B needs to win; legal range 1..`RODADAS`.
- `MAX_INVALIDAS`, 3: invalid plays that void the match; legal range 1..15.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `iniciar` input 1: start or restart a match; level sampled on the clock edge.
- `jogar` input 1: one-cycle play strobe; `s1`/`s2` are sampled when it is high.
- `s1` input 1: comparator hit flag (B's pattern equals the inverse of A's pattern, and the play is valid).
- `s2` input 1: comparator validity flag (0 means either player used an all-equal pattern).
- `acertos` output 4: hits in the current match.
- `rodada` output 4: valid rounds played.
- `invalidas` output 4: invalid plays.
- `ocupado` output 1: high while in `JOGANDO`.
- `fim` output 1: high while in `FIM`.
- `resultado` output 2: 00 no result, 01 A wins, 10 B wins, 11 voided.
- `ultimo` output 2: last sampled play; 00 none, 01 miss, 10 hit, 11 invalid.

## Operation
- FSM states: `OCIOSO`, `JOGANDO`, `FIM`. The state and all outputs are registered.
- In `OCIOSO`:
  - `iniciar=1` clears `acertos`, `rodada`, `invalidas`, `resultado` and `ultimo`, then moves to `JOGANDO`.
  - `jogar` is ignored.
- In `JOGANDO`, on `jogar=1`:
  - `s2=0`: `invalidas`+1 and `ultimo`=11. `rodada` and `acertos` are unchanged. `s2=0` dominates even if `s1=1`.
  - `s2=1, s1=1`: `rodada`+1, `acertos`+1, `ultimo`=10.
  - `s2=1, s1=0`: `rodada`+1, `ultimo`=01.
- End checks use the post-update values and are evaluated on the same edge, in this priority order:
  1. `invalidas == MAX_INVALIDAS`: `resultado`=11, go to `FIM`.
  2. `acertos == ACERTOS_VITORIA`: `resultado`=10, go to `FIM`.
  3. `rodada - acertos == RODADAS - ACERTOS_VITORIA + 1` (misses have made B's target unreachable): `resultado`=01, go to `FIM`.
- Otherwise the block stays in `JOGANDO`.
- `iniciar` is ignored in `JOGANDO`; a match cannot be aborted except by `rst`.
- In `FIM`:
  - Counters and `resultado` hold.
  - `jogar` is ignored.
  - `iniciar=1` behaves exactly as in `OCIOSO` and starts a new match.
- Counters are 4-bit unsigned. The parameter ranges guarantee no wrap.
- The miss count is computed as a 4-bit difference `rodada - acertos`; it is never negative.

## Timing
- Reset values: state `OCIOSO`, all counters 0, `resultado`=00, `ultimo`=00, `ocupado`=0, `fim`=0.
- `rst` takes effect immediately, regardless of the clock. An `rst` mid-match discards the match.
- `iniciar` sampled at edge N: `ocupado`=1 and counters=0 are visible after edge N. The first `jogar` is accepted at edge N+1.
- Play latency: `jogar` at edge N updates the counters and `ultimo` after edge N.
  - If that play ends the match, `fim`=1, `ocupado`=0 and `resultado` are valid after the same edge N.
- Back-to-back `jogar` on consecutive cycles: each one is counted. Throughput is one play per cycle.
- Simultaneous `iniciar` and `jogar`:
  - In `OCIOSO` or `FIM`: the start wins and that `jogar` is not counted.
  - In `JOGANDO`: the play is counted and `iniciar` is ignored.
- `s1`/`s2` must be stable at the edge where `jogar=1`. The block does not filter glitches on them.

## Test plan
- Reset, then `iniciar`, then 3 hits (`s1=1, s2=1`) with defaults -> `acertos`=3, `rodada`=3, `resultado`=10, `fim`=1 after the 3rd strobe.
- Sequence hit, miss, miss, miss with defaults -> after the 4th strobe `rodada`=4, `acertos`=1, `resultado`=01, `fim`=1 (early A win).
- 3 strobes with `s2=0`, one of them with `s1=1` -> `invalidas`=3, `rodada`=0, `resultado`=11, `ultimo`=11.
- `jogar` pulsed in `OCIOSO` and in `FIM`, then `iniciar` and `jogar` in the same cycle from `FIM` -> no count changes; after the edge the counters are cleared, `ocupado`=1, `ultimo`=00.
- Mid-match (`acertos`=2, `rodada`=2), assert `rst` between edges -> all outputs at reset values before the next edge.
- Back-to-back 5 strobes: miss, hit, invalid, hit, hit -> final `rodada`=4, `acertos`=3, `invalidas`=1, `resultado`=10 on the 5th edge.
